mem_req_port: RTL and testbench
===============================

# mem_req_port

Parametrised byte-addressed memory with a valid/ready request/response port, big-endian multi-byte words, per-byte write enables and bounds checking. It is the next-generation storage block: node-logic FSMs (e.g. the sink-detection logic) issue word reads/writes through it instead of driving the raw array combinationally. One request is outstanding at a time, and every request, read or write, gets exactly one response.

## Interface
Parameters:
- MEM_DEPTH, 1024: number of byte locations.
- MEM_WIDTH, 8: bits per location; fixed at 8.
- WORD_BYTES, 2: bytes per word, legal range 1..8.
- ADDR_WIDTH, 16: request address width.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address of the word's most-significant byte.
- req_wdata  in  WORD_BYTES*8  write data.
- req_be  in  WORD_BYTES  byte enables; bit k enables data bits [8k+7:8k].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  WORD_BYTES*8  read data; 0 for writes and errors.
- rsp_err  out  1  out-of-range access.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Memory contents are not reset.
- IDLE: req_ready=1. If req_valid is high at the edge, latch wr/addr/wdata/be and go to BUSY.
- BUSY: req_ready=0. Perform the access at the next edge, register the response, go to RESP.
- RESP: rsp_valid=1 and response fields held stable. If rsp_ready is high at the edge, return to IDLE.
- Byte mapping is big-endian. Lane k (data bits [8k+7:8k]) maps to memory address addr + (WORD_BYTES-1-k). Lane WORD_BYTES-1 is at addr.
- Misaligned addresses are legal; there is no alignment requirement.
- Range check: if addr + WORD_BYTES > MEM_DEPTH, compute the sum in ADDR_WIDTH+4 bits so there is no wrap. On error:
  - rsp_err=1 and rsp_rdata=0.
  - No byte is written, not even the in-range lanes.
  - Addresses never wrap.
- Write: only lanes with be[k]=1 are updated. Response has rsp_rdata=0, rsp_err=0.
- be=0 on a write: legal no-op that still produces a response.
- Read: req_be is ignored; all lanes are returned.
- Read-after-write to the same bytes in consecutive transactions returns the new data, because transactions are serialised.

## Timing
- Accept at edge N (req_valid & req_ready).
- Memory access and response register update at edge N+1; rsp_valid is high from N+1.
- With rsp_ready held high, the handshake completes at N+2 and req_ready is high again after N+2. Peak throughput is 1 transaction per 3 cycles.
- Back-pressure: rsp_valid stays high and the response stays stable indefinitely while rsp_ready=0. req_ready stays 0 throughout.
- req_* inputs are ignored outside IDLE. Latched values are used, so the requester may change req_* after acceptance.
- Reset asserted in BUSY, before edge N+1: the write is not performed and all outputs take their reset values immediately (asynchronously).
- Reset asserted in RESP: the response is dropped.
- Deassertion: the first accept is possible at the first edge after reset falls.

## Structure
- Package mem_req_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - the MEM_WIDTH constant;
  - a function that maps lane index to address offset.
- Sub-module mem_byte_array holds the storage: MEM_DEPTH x 8 bits, WORD_BYTES-lane synchronous write with per-lane enables, combinational word read. The FSM wrapper registers the read result.
- The address adder and range check live in the top module.

## Test plan
Defaults WORD_BYTES=2, MEM_DEPTH=1024.
- Write 0xA55A to addr 0, be=2'b11, then read addr 0 -> rdata=0xA55A, err=0. mem[0]=0xA5, mem[1]=0x5A. Each response arrives 1 cycle after accept.
- Write 0x1234 to addr 4 with be=11, then 0xFFEE with be=01, then read addr 4 -> 0x12EE. Read addr 5 (misaligned) -> 0xEExx, where xx is the prior content of mem[6] (pre-written as 0x77 -> 0xEE77).
- Write 0xBEEF to addr 1023 -> err=1, mem[1023] unchanged. Read 1023 -> err=1, rdata=0. Read 1022 -> err=0.
- Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0 throughout. Second request presented during the stall is not accepted until after the response handshake.
- Assert reset in BUSY of a write of 0xCAFE to addr 8 (prior content 0x0000) -> outputs go to reset values immediately. A subsequent read of addr 8 returns 0x0000.
- Parameter sweep WORD_BYTES=4: write 0x01020304 to addr 10 -> mem[10..13]=01,02,03,04. Read addr 1021 -> err=1. Read addr 1020 -> err=0.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared definitions for the request-port memory.
// Covers the FSM encoding, the byte width and the big-endian lane-to-offset mapping.
package mem_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int MEM_WIDTH = 8;

    // Big-endian: the most-significant lane sits at the request address.
    function automatic int lane_offset(input int lane, input int word_bytes);
        return word_bytes - 1 - lane;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with a WORD_BYTES-lane synchronous write and a combinational word read.
// The array is not reset.
module mem_byte_array #(
    parameter int MEM_DEPTH  = 1024,
    parameter int WORD_BYTES = 2,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                                         clock,
    input  logic                                         we_i,
    input  logic [IDX_W-1:0]                             addr_i,
    input  logic [WORD_BYTES-1:0]                        be_i,
    input  logic [WORD_BYTES*mem_req_pkg::MEM_WIDTH-1:0] wdata_i,
    output logic [WORD_BYTES*mem_req_pkg::MEM_WIDTH-1:0] rdata_o
);
    import mem_req_pkg::*;

    logic [MEM_WIDTH-1:0] mem_q     [MEM_DEPTH];
    logic [IDX_W-1:0]     lane_addr [WORD_BYTES];

    // Lane addresses may run past the array only when the access is out of range.
    // Such accesses are never written, and their read data is discarded upstream.
    always_comb begin
        for (int k = 0; k < WORD_BYTES; k++) begin
            lane_addr[k] = addr_i + IDX_W'(lane_offset(k, WORD_BYTES));
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            rdata_o[k*MEM_WIDTH +: MEM_WIDTH] = mem_q[lane_addr[k]];
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (we_i && be_i[k]) begin
                mem_q[lane_addr[k]] <= wdata_i[k*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

endmodule

// File: rtl/mem_req_port.sv
// Single-outstanding valid/ready front end for mem_byte_array.
// It latches the request, range-checks it, performs the access and holds the response until it is accepted.
module mem_req_port #(
    parameter int MEM_DEPTH  = 1024,
    parameter int MEM_WIDTH  = 8,
    parameter int WORD_BYTES = 2,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_wr,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [WORD_BYTES*MEM_WIDTH-1:0] req_wdata,
    input  logic [WORD_BYTES-1:0]           req_be,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [WORD_BYTES*MEM_WIDTH-1:0] rsp_rdata,
    output logic                            rsp_err
);
    import mem_req_pkg::*;

    localparam int DW    = WORD_BYTES * MEM_WIDTH;
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int SUM_W = ADDR_WIDTH + 4;

    state_e                  state_q, state_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DW-1:0]           wdata_q, wdata_d;
    logic [WORD_BYTES-1:0]   be_q, be_d;
    logic [DW-1:0]           rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [SUM_W-1:0]        end_addr;
    logic                    range_err;
    logic                    mem_we;
    logic [DW-1:0]           arr_rdata;

    // The widened sum cannot wrap, so requests near the top of the address space are still flagged.
    assign end_addr  = {4'b0, addr_q} + SUM_W'(WORD_BYTES);
    assign range_err = end_addr > SUM_W'(MEM_DEPTH);
    assign mem_we    = (state_q == BUSY) && wr_q && !range_err;

    mem_byte_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .WORD_BYTES(WORD_BYTES),
        .IDX_W     (IDX_W)
    ) u_array (
        .clock  (clock),
        .we_i   (mem_we),
        .addr_i (addr_q[IDX_W-1:0]),
        .be_i   (be_q),
        .wdata_i(wdata_q),
        .rdata_o(arr_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                rdata_d = (wr_q || range_err) ? '0 : arr_rdata;
                err_d   = range_err;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_req_port.sv
// Directed checks of mem_req_port at WORD_BYTES=2 and WORD_BYTES=4.
// The expected values are hand-computed from the big-endian byte map.
module tb_mem_req_port;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        req_valid2 = 0, req_wr2 = 0, rsp_ready2 = 0;
    logic [15:0] req_addr2 = 0, req_wdata2 = 0;
    logic [1:0]  req_be2 = 0;
    logic        req_ready2, rsp_valid2, rsp_err2;
    logic [15:0] rsp_rdata2;

    logic        req_valid4 = 0, req_wr4 = 0, rsp_ready4 = 0;
    logic [15:0] req_addr4 = 0;
    logic [31:0] req_wdata4 = 0;
    logic [3:0]  req_be4 = 0;
    logic        req_ready4, rsp_valid4, rsp_err4;
    logic [31:0] rsp_rdata4;

    mem_req_port #(.MEM_DEPTH(1024), .MEM_WIDTH(8), .WORD_BYTES(2), .ADDR_WIDTH(16)) u_dut2 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_wr(req_wr2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .req_be(req_be2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
    );

    mem_req_port #(.MEM_DEPTH(1024), .MEM_WIDTH(8), .WORD_BYTES(4), .ADDR_WIDTH(16)) u_dut4 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_wr(req_wr4),
        .req_addr(req_addr4), .req_wdata(req_wdata4), .req_be(req_be4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction on the 2-byte port; lat counts edges from accept to rsp_valid.
    task automatic txn2(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input logic [1:0] be, output logic [15:0] rd, output logic er,
                        output int lat);
        @(negedge clock);
        req_wr2 = wr; req_addr2 = a; req_wdata2 = wd; req_be2 = be; req_valid2 = 1;
        @(posedge clock); #1;
        req_valid2 = 0; req_wdata2 = 16'h0; req_addr2 = 16'h0;
        lat = 0;
        while (!rsp_valid2 && lat < 20) begin
            @(posedge clock); #1; lat++;
        end
        rd = rsp_rdata2; er = rsp_err2;
        rsp_ready2 = 1;
        @(posedge clock); #1;
        rsp_ready2 = 0;
    endtask

    // The same transaction sequence on the 4-byte port.
    task automatic txn4(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
        @(negedge clock);
        req_wr4 = wr; req_addr4 = a; req_wdata4 = wd; req_be4 = be; req_valid4 = 1;
        @(posedge clock); #1;
        req_valid4 = 0; req_wdata4 = 32'h0; req_addr4 = 16'h0;
        lat = 0;
        while (!rsp_valid4 && lat < 20) begin
            @(posedge clock); #1; lat++;
        end
        rd = rsp_rdata4; er = rsp_err4;
        rsp_ready4 = 1;
        @(posedge clock); #1;
        rsp_ready4 = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        logic [31:0] rd4;
        logic        er;
        int          lat;

        // Reset values.
        #12;
        chk("rst_req_ready", req_ready2, 1);
        chk("rst_rsp_valid", rsp_valid2, 0);
        chk("rst_rdata", rsp_rdata2, 0);
        chk("rst_err", rsp_err2, 0);
        @(negedge clock); reset = 0;

        // Basic write/read, big-endian placement.
        txn2(1, 16'd0, 16'hA55A, 2'b11, rd, er, lat);
        chk("wr0_lat", lat, 1); chk("wr0_rdata", rd, 0); chk("wr0_err", er, 0);
        txn2(1, 16'd2, 16'h3300, 2'b10, rd, er, lat);
        txn2(0, 16'd0, 16'h0, 2'b00, rd, er, lat);
        chk("rd0_lat", lat, 1); chk("rd0_rdata", rd, 16'hA55A); chk("rd0_err", er, 0);
        txn2(0, 16'd1, 16'h0, 2'b00, rd, er, lat);
        chk("rd1_rdata", rd, 16'h5A33);

        // Byte enables and misaligned access.
        txn2(1, 16'd6, 16'h7700, 2'b10, rd, er, lat);
        txn2(1, 16'd4, 16'h1234, 2'b11, rd, er, lat);
        txn2(1, 16'd4, 16'hFFEE, 2'b01, rd, er, lat);
        txn2(0, 16'd4, 16'h0, 2'b11, rd, er, lat);
        chk("be01_rdata", rd, 16'h12EE);
        txn2(0, 16'd5, 16'h0, 2'b00, rd, er, lat);
        chk("misalign_rdata", rd, 16'hEE77);
        txn2(1, 16'd4, 16'hFFFF, 2'b00, rd, er, lat);
        chk("be00_lat", lat, 1); chk("be00_err", er, 0);
        txn2(0, 16'd4, 16'h0, 2'b00, rd, er, lat);
        chk("be00_noop", rd, 16'h12EE);

        // Range boundary.
        txn2(1, 16'd1022, 16'h1133, 2'b11, rd, er, lat);
        chk("wr1022_err", er, 0);
        txn2(1, 16'd1023, 16'hBEEF, 2'b11, rd, er, lat);
        chk("wr1023_err", er, 1); chk("wr1023_rdata", rd, 0);
        txn2(0, 16'd1023, 16'h0, 2'b11, rd, er, lat);
        chk("rd1023_err", er, 1); chk("rd1023_rdata", rd, 0);
        txn2(0, 16'd1022, 16'h0, 2'b11, rd, er, lat);
        chk("rd1022_err", er, 0); chk("rd1022_rdata", rd, 16'h1133);
        txn2(0, 16'hFFFF, 16'h0, 2'b11, rd, er, lat);
        chk("rdFFFF_nowrap_err", er, 1);

        // Back-pressure with a second request waiting.
        @(negedge clock);
        req_wr2 = 0; req_addr2 = 16'd0; req_valid2 = 1;
        @(posedge clock); #1;
        req_addr2 = 16'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("bp_rsp_valid", rsp_valid2, 1);
            chk("bp_rdata", rsp_rdata2, 16'hA55A);
            chk("bp_req_ready", req_ready2, 0);
        end
        rsp_ready2 = 1;
        @(posedge clock); #1;
        rsp_ready2 = 0;
        chk("bp_idle_ready", req_ready2, 1);
        @(posedge clock); #1;
        chk("bp_2nd_accepted", req_ready2, 0);
        req_valid2 = 0; req_addr2 = 16'd0;
        @(posedge clock); #1;
        chk("bp_2nd_valid", rsp_valid2, 1);
        chk("bp_2nd_rdata", rsp_rdata2, 16'h12EE);
        rsp_ready2 = 1;
        @(posedge clock); #1;
        rsp_ready2 = 0;

        // Reset while a write is in BUSY.
        txn2(1, 16'd8, 16'h0000, 2'b11, rd, er, lat);
        txn2(0, 16'd4, 16'h0, 2'b11, rd, er, lat);
        @(negedge clock);
        req_wr2 = 1; req_addr2 = 16'd8; req_wdata2 = 16'hCAFE; req_be2 = 2'b11; req_valid2 = 1;
        @(posedge clock); #1;
        req_valid2 = 0;
        chk("busy_before_rst", req_ready2, 0);
        #2 reset = 1;
        #1;
        chk("async_req_ready", req_ready2, 1);
        chk("async_rsp_valid", rsp_valid2, 0);
        chk("async_rdata", rsp_rdata2, 0);
        chk("async_err", rsp_err2, 0);
        @(posedge clock);
        @(negedge clock); reset = 0;
        txn2(0, 16'd8, 16'h0, 2'b11, rd, er, lat);
        chk("rst_write_dropped", rd, 16'h0000);

        // Four-byte words.
        txn4(1, 16'd14, 32'h05060708, 4'b1111, rd4, er, lat);
        txn4(1, 16'd10, 32'h01020304, 4'b1111, rd4, er, lat);
        chk("w4_wr_lat", lat, 1); chk("w4_wr_err", er, 0);
        txn4(0, 16'd10, 32'h0, 4'b0000, rd4, er, lat);
        chk("w4_rd10", rd4, 32'h01020304);
        txn4(0, 16'd12, 32'h0, 4'b0000, rd4, er, lat);
        chk("w4_rd12", rd4, 32'h03040506);
        txn4(0, 16'd1021, 32'h0, 4'b1111, rd4, er, lat);
        chk("w4_rd1021_err", er, 1); chk("w4_rd1021_rdata", rd4, 0);
        txn4(0, 16'd1020, 32'h0, 4'b1111, rd4, er, lat);
        chk("w4_rd1020_err", er, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
